fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage directly upstream of the IF/ID pipeline register. Keeps the fetch PC and issues word requests to instruction memory over a valid/ready request channel, with one request outstanding at most. Each response is buffered with its PC in a small queue, and that queue feeds the `ins`/`pc` inputs of IF/ID. Branch/jump redirects from later stages flush the queue, retarget the PC and discard any in-flight response.

## Interface
- `WordSize`, default 32: PC/address width.
- `ResetVector`, default 0: first fetch address after reset.
- `QDepth`, default 2: fetch-queue entries; must be ≥1.

- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `imem_req_valid`  out  1  request valid.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_req_addr`  out  WordSize  word-aligned fetch address.
- `imem_resp_valid`  in  1  response data valid; at most one per accepted request, arriving ≥1 cycle after acceptance.
- `imem_resp_data`  in  32  instruction word.
- `redirect_valid`  in  1  flush and retarget, from EX.
- `redirect_pc`  in  WordSize  new fetch PC; bits [1:0] ignored and treated as 0.
- `stall`  in  1  decode cannot consume this cycle.
- `ins_valid`  out  1  queue head valid.
- `ins`  out  32  head instruction.
- `pc_out`  out  WordSize  head PC.

## Operation
- State machine (`fetch_state_t`):
  - REQ: may issue a request.
  - WAIT: one request accepted, response pending.
  - DROP: response pending but stale; it must be discarded.
- `imem_req_valid` = (state==REQ) && !redirect_valid && (count < QDepth). `imem_req_addr` = `fetch_pc`.
- REQ, request accepted (valid && ready):
  - latch `req_pc` <= `fetch_pc`;
  - `fetch_pc` <= `fetch_pc` + 4, modulo 2^WordSize (wraps silently);
  - go to WAIT.
- WAIT, `imem_resp_valid`: push {`req_pc`, `imem_resp_data`} into the queue, go to REQ.
- DROP, `imem_resp_valid`: discard the data, go to REQ.
- Pop: `ins_valid` && !`stall` && !`redirect_valid`. Push and pop in the same cycle are legal; count is unchanged.
- No overflow is possible: a request issues only when count < QDepth, and at most one request is outstanding.
- Redirect has highest priority:
  - queue cleared (count ← 0; same-cycle push/pop suppressed);
  - `fetch_pc` <= {redirect_pc[WordSize-1:2], 2'b00};
  - next state: from REQ → REQ; from WAIT with no response this cycle → DROP; from WAIT with a response this cycle → REQ (response dropped); from DROP → REQ if a response arrives this cycle, else stay in DROP.
- A response arriving in REQ is ignored; a simulation assertion flags it.
- Reset values: state REQ, count 0, `fetch_pc` = ResetVector, `req_pc` 0.
  - Outputs during and right after reset: `ins_valid` 0, `ins` 0, `pc_out` 0, `imem_req_valid` 0 while `rst` is high.
  - A reset mid-operation abandons any outstanding request.

## Timing
- Cycle 0 after `rst` falls: `imem_req_valid`=1, addr=ResetVector.
- Request accepted in cycle N, response in N+1 → `ins_valid`=1 in N+2 (queue output is registered).
- Back-to-back: with ready=1 and 1-cycle response, one instruction every 2 cycles (single outstanding request).
- Redirect in cycle R:
  - `imem_req_valid`=0 in R;
  - `ins_valid`=0 from R+1;
  - earliest request at the new PC in R+1 (REQ path);
  - earliest `ins_valid` with the new PC in R+3.
- `stall` only holds the queue head. Requests continue until the queue is full.
- Outputs `ins`, `pc_out`, `ins_valid` are driven from registers only. `imem_req_valid` is combinational on `redirect_valid`.

## Structure
- `fetch_pkg`:
  - `fetch_state_t` enum {FETCH_REQ, FETCH_WAIT, FETCH_DROP};
  - `fetch_entry_t` struct {pc, ins};
  - constant `PcStep` = 4.
- Sub-module `fetch_queue`:
  - parameterised synchronous FIFO of `fetch_entry_t`, depth QDepth;
  - ports: push, pop, flush, full, empty, head;
  - flush overrides push/pop.

## Test plan
- Reset release, ready=1, 1-cycle response 0x00500093 → req addr 0x0 in cycle 0, 0x4 in cycle 2; `ins`=0x00500093 with `pc_out`=0x0 and `ins_valid`=1 in cycle 2.
- `stall`=1 held → after 2 responses (QDepth=2) `imem_req_valid` stays 0. Release `stall` → pops in PC order 0x0, 0x4, then a request for 0x8 issues.
- Redirect to 0x100 while in WAIT; stale response arrives 3 cycles later → stale response discarded. Next request addr=0x100, and first `pc_out`=0x100.
- Redirect in the same cycle as a response and a non-stalled pop → queue empty next cycle, no push, and the response is not output.
- Redirect with `redirect_pc`=0x103 → `imem_req_addr`=0x100. Redirect to 0xFFFFFFFC → next address wraps to 0x0.
- `rst` asserted while in WAIT with 1 entry queued → next cycle `ins_valid`=0 and state REQ. After `rst` falls, addr=ResetVector.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int PcStep = 4;
  localparam int InsW   = 32;

  typedef enum logic [1:0] {
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_DROP
  } fetch_state_t;

  // Default queue entry for the 32-bit PC configuration.
  typedef struct packed {
    logic [31:0]     pc;
    logic [InsW-1:0] ins;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Shift-style synchronous FIFO. Slot 0 is always the head, so the head is
// a plain register with no read mux; flush overrides push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  QDepth  = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  entry_t din,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  localparam int CntW = $clog2(QDepth + 1);

  entry_t          mem   [QDepth];
  entry_t          above [QDepth];
  logic [CntW-1:0] count;
  logic [CntW-1:0] count_nxt;
  logic [CntW-1:0] wr_idx;
  logic            nempty;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CntW'(QDepth));
  assign empty   = !nempty;
  assign head    = mem[0];
  assign do_pop  = pop && nempty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  // On a simultaneous pop the tail slides down one, so the write lands one lower.
  assign wr_idx  = do_pop ? count - 1'b1 : count;

  // Each slot's shift source; the top slot refills with zero.
  for (genvar g = 0; g < QDepth; g++) begin : g_above
    if (g < QDepth - 1) begin : g_mid
      assign above[g] = mem[g+1];
    end else begin : g_top
      assign above[g] = '0;
    end
  end

  // Occupancy after this cycle's flush/push/pop.
  always_comb begin
    count_nxt = count;
    if (flush)                  count_nxt = '0;
    else if (do_push && !do_pop) count_nxt = count + 1'b1;
    else if (do_pop && !do_push) count_nxt = count - 1'b1;
  end

  // Storage and occupancy; the non-empty flag is registered so ins_valid
  // comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QDepth; i++) mem[i] <= '0;
      count  <= '0;
      nempty <= 1'b0;
    end else begin
      count  <= count_nxt;
      nempty <= (count_nxt != '0);
      for (int i = 0; i < QDepth; i++) begin
        if (do_push && wr_idx == CntW'(i)) mem[i] <= din;
        else if (do_pop)                   mem[i] <= above[i];
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: keeps the fetch PC, issues one imem request at a time,
// buffers responses with their PC, and flushes on redirects from EX.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                  WordSize    = 32,
  parameter logic [WordSize-1:0] ResetVector = '0,
  parameter int                  QDepth      = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [WordSize-1:0] imem_req_addr,
  input  logic                imem_resp_valid,
  input  logic [InsW-1:0]     imem_resp_data,
  input  logic                redirect_valid,
  input  logic [WordSize-1:0] redirect_pc,
  input  logic                stall,
  output logic                ins_valid,
  output logic [InsW-1:0]     ins,
  output logic [WordSize-1:0] pc_out
);

  typedef struct packed {
    logic [WordSize-1:0] pc;
    logic [InsW-1:0]     ins;
  } entry_t;

  fetch_state_t        state, state_nxt;
  logic [WordSize-1:0] fetch_pc;
  logic [WordSize-1:0] req_pc;
  logic                req_fire;
  logic                push, pop, full, empty;
  entry_t              head;
  logic                unused_rpc_lo;

  // Redirect targets are word aligned; the low bits are dropped.
  assign unused_rpc_lo = ^redirect_pc[1:0];

  assign imem_req_valid = !rst && (state == FETCH_REQ) && !redirect_valid && !full;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign push           = (state == FETCH_WAIT) && imem_resp_valid && !redirect_valid;
  assign pop            = ins_valid && !stall && !redirect_valid;
  assign ins_valid      = !empty;
  assign ins            = head.ins;
  assign pc_out         = head.pc;

  fetch_queue #(
    .QDepth (QDepth),
    .entry_t(entry_t)
  ) u_queue (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(redirect_valid),
    .din  ('{pc: req_pc, ins: imem_resp_data}),
    .full (full),
    .empty(empty),
    .head (head)
  );

  // Next state: a redirect while a response is still owed parks in DROP
  // until that stale response shows up.
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH_REQ:  if (!redirect_valid && req_fire) state_nxt = FETCH_WAIT;
      FETCH_WAIT: begin
        if (imem_resp_valid)     state_nxt = FETCH_REQ;
        else if (redirect_valid) state_nxt = FETCH_DROP;
      end
      FETCH_DROP: if (imem_resp_valid) state_nxt = FETCH_REQ;
      default:    state_nxt = FETCH_REQ;
    endcase
  end

  // State register; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH_REQ;
    else     state <= state_nxt;
  end

  // Fetch PC advances on each accepted request; redirect wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= ResetVector;
      req_pc   <= '0;
    end else begin
      if (req_fire) req_pc <= fetch_pc;
      if (redirect_valid)
        fetch_pc <= {redirect_pc[WordSize-1:2], 2'b00};
      else if (req_fire)
        fetch_pc <= fetch_pc + WordSize'(PcStep);
    end
  end

  // A response with nothing outstanding means the memory side is broken.
  assert property (@(posedge clk) disable iff (rst)
    !(state == FETCH_REQ && imem_resp_valid));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench: a reference program stream is queued on every reset or
// redirect, a memory model answers requests, and a monitor checks each pop.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        ins_valid;
  logic [31:0] ins;
  logic [31:0] pc_out;

  always #5 clk = ~clk;

  fetch_unit #(.WordSize(32), .ResetVector(32'h0), .QDepth(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall(stall), .ins_valid(ins_valid),
    .ins(ins), .pc_out(pc_out)
  );

  typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          chk_cnt = 0, pass_cnt = 0, pops = 0;
  int          lat_min = 1, lat_max = 1, ready_pct = 100;
  int          pend = 0;
  logic [31:0] pend_addr = 32'h0;

  function automatic logic [31:0] imem_word(logic [31:0] a);
    if (a == 32'h0) return 32'h00500093;
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_b(string name, logic act, logic exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Sequential program order from a (word-aligned) start PC.
  task automatic restart_stream(logic [31:0] start);
    logic [31:0] p;
    exp_q.delete();
    for (int i = 0; i < 128; i++) begin
      p = {start[31:2], 2'b00} + 32'(4 * i);
      exp_q.push_back('{p, imem_word(p)});
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Returns in the first cycle after rst falls.
  task automatic reset_release();
    rst = 1'b1; redirect_valid = 1'b0; restart_stream(32'h0);
    step(); step();
    rst = 1'b0;
  endtask

  // Memory model: latches accepted requests, answers after lat cycles.
  initial begin
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) pend = 0;
      else if (imem_req_valid && imem_req_ready) begin
        pend      = int'($urandom_range(lat_max, lat_min));
        pend_addr = imem_req_addr;
      end
      @(posedge clk); #2;
      imem_resp_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = imem_word(pend_addr);
        end
      end
      imem_req_ready = (int'($urandom_range(99)) < ready_pct);
    end
  end

  // Monitor: every consumed head must be the next instruction in program order.
  initial forever begin
    @(negedge clk);
    if (!rst && ins_valid && !stall && !redirect_valid) begin
      pops++;
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL pop_unexpected: got pc %h, expected no output", pc_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("pop_pc", pc_out, mon_e.pc);
        check("pop_ins", ins, mon_e.ins);
      end
    end
  end

  int since = 0;
  int r;

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    restart_stream(32'h0);

    // Reset values and first fetch
    step(); settle();
    check_b("rst_req_valid", imem_req_valid, 1'b0);
    check_b("rst_ins_valid", ins_valid, 1'b0);
    check("rst_ins", ins, 32'h0);
    check("rst_pc_out", pc_out, 32'h0);
    step(); rst = 1'b0;
    settle();
    check_b("c0_req_valid", imem_req_valid, 1'b1);
    check("c0_req_addr", imem_req_addr, 32'h0);
    step(); settle();
    check_b("c1_req_valid", imem_req_valid, 1'b0);
    step(); settle();
    check_b("c2_ins_valid", ins_valid, 1'b1);
    check("c2_ins", ins, 32'h00500093);
    check("c2_pc_out", pc_out, 32'h0);
    check("c2_req_addr", imem_req_addr, 32'h4);

    // Stall fills the queue, then drains in order
    step(); stall = 1'b1; reset_release();
    step(); step(); settle();
    check("st_req_addr4", imem_req_addr, 32'h4);
    step(); step(); settle();
    check_b("st_full_no_req", imem_req_valid, 1'b0);
    step(); step(); settle();
    check_b("st_full_hold", imem_req_valid, 1'b0);
    check("st_head_pc", pc_out, 32'h0);
    step(); stall = 1'b0; settle();
    check("st_pop0", pc_out, 32'h0);
    step(); settle();
    check("st_pop4", pc_out, 32'h4);
    check_b("st_req8_valid", imem_req_valid, 1'b1);
    check("st_req8_addr", imem_req_addr, 32'h8);

    // Redirect in WAIT, stale response three cycles later
    step(); lat_min = 4; lat_max = 4; reset_release();
    step(); redirect_valid = 1'b1; redirect_pc = 32'h100; restart_stream(32'h100);
    settle(); check_b("rd_req_blocked", imem_req_valid, 1'b0);
    step(); redirect_valid = 1'b0; lat_min = 1; lat_max = 1;
    settle(); check_b("rd_drop_no_req", imem_req_valid, 1'b0);
    step(); step(); settle();
    check_b("rd_stale_no_req", imem_req_valid, 1'b0);
    step(); settle();
    check_b("rd_req_new", imem_req_valid, 1'b1);
    check("rd_req_addr", imem_req_addr, 32'h100);
    check_b("rd_stale_hidden", ins_valid, 1'b0);
    step(); step(); settle();
    check_b("rd_ins_valid", ins_valid, 1'b1);
    check("rd_pc_out", pc_out, 32'h100);

    // Redirect together with a response and a would-be pop
    step(); stall = 1'b1; reset_release();
    step(); step(); settle();
    check_b("rp_one_queued", ins_valid, 1'b1);
    step(); stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200;
    restart_stream(32'h200);
    step(); redirect_valid = 1'b0; settle();
    check_b("rp_flushed", ins_valid, 1'b0);
    check("rp_req_addr", imem_req_addr, 32'h200);
    step(); settle();
    check_b("rp_resp_dropped", ins_valid, 1'b0);
    step(); settle();
    check("rp_new_pc", pc_out, 32'h200);

    // Redirect alignment and address wrap
    step(); ready_pct = 0; reset_release();
    redirect_valid = 1'b1; redirect_pc = 32'h103; restart_stream(32'h103);
    step(); redirect_pc = 32'hFFFF_FFFC; restart_stream(32'hFFFF_FFFC);
    settle(); check("al_addr", imem_req_addr, 32'h100);
    step(); redirect_valid = 1'b0; ready_pct = 100;
    settle(); check("wr_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    step(); step(); settle();
    check("wr_pc_out", pc_out, 32'hFFFF_FFFC);
    check("wr_next_addr", imem_req_addr, 32'h0);

    // Reset while WAIT with one entry queued
    step(); stall = 1'b1; reset_release();
    step(); step(); lat_min = 3; lat_max = 3;
    step(); settle();
    check_b("mr_queued", ins_valid, 1'b1);
    step(); rst = 1'b1; lat_min = 1; lat_max = 1; restart_stream(32'h0);
    step(); rst = 1'b0; settle();
    check_b("mr_ins_valid", ins_valid, 1'b0);
    check("mr_pc_out", pc_out, 32'h0);
    check_b("mr_req_valid", imem_req_valid, 1'b1);
    check("mr_req_addr", imem_req_addr, 32'h0);

    // Random traffic against the program-order model
    stall = 1'b0; pops = 0;
    for (int c = 0; c < 4000; c++) begin
      step();
      rst = 1'b0; redirect_valid = 1'b0;
      if (c % 500 == 0) begin
        ready_pct = int'($urandom_range(100, 30));
        lat_min = 1; lat_max = int'($urandom_range(4, 1));
      end
      stall = (int'($urandom_range(99)) < 30);
      r = int'($urandom_range(999));
      if (r < 5) begin
        rst = 1'b1; restart_stream(32'h0); since = 0;
      end else if (r < 40 || since > 150) begin
        redirect_valid = 1'b1; redirect_pc = $urandom();
        restart_stream(redirect_pc); since = 0;
      end else since++;
    end
    step(); rst = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
    repeat (10) step();
    check_b("rand_progress", pops > 300, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
